// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg
// Shared FSM state encoding and grant constants for mem_port_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick
// Winner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise data has priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = GRANT_FETCH;
    if (if_req && d_req) begin
      grant = ~last_grant;
    end else if (d_req) begin
      grant = GRANT_DATA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = d_req ? GRANT_DATA : GRANT_FETCH;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Shares one memory port between fetch and data requesters.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m
);

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic          grant;
  logic          start;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign start = (state == IDLE) && (if_req || d_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (grant == GRANT_DATA) ? GNT_D : GNT_I;
      GNT_D,
      GNT_I:   if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset removes them at once.
  assign mem_req   = (state == GNT_D) || (state == GNT_I);
  assign mem_we    = (state == GNT_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state == DONE) && (last_grant == GRANT_FETCH);
  assign d_ack     = (state == DONE) && (last_grant == GRANT_DATA);
  assign stall_f   = if_req && !if_ack;
  assign stall_m   = d_req && !d_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (start) begin
        last_grant <= grant;
        if (grant == GRANT_DATA) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
        end
      end
      if (mem_ready) begin
        if (state == GNT_I) if_rdata <= mem_rdata;
        if ((state == GNT_D) && !we_q) d_rdata <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Directed vector table plus hand sequences for reset and contention cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, stall_f, stall_m;

  int checks = 0;
  int fails  = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_f   (stall_f),
    .stall_m   (stall_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [133:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic rdy,
                     input logic [31:0] rd, input logic mreq, input logic mwe,
                     input logic [31:0] maddr, input logic [31:0] mwd, input logic iack,
                     input logic dack, input logic [31:0] ird, input logic [31:0] drd,
                     input logic sf, input logic sm);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.mem_ready = rdy; v.mem_rdata = rd;
    v.exp = {mreq, mwe, maddr, mwd, iack, dack, ird, drd, sf, sm};
    vecs.push_back(v);
  endtask

  function automatic logic [133:0] outs();
    return {mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, stall_f, stall_m};
  endfunction

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Acks must never coincide, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (if_ack && d_ack) begin
        fails++;
        $display("FAIL ack_overlap: got if_ack=%0b d_ack=%0b expected not both", if_ack, d_ack);
      end
    end
  end

  logic grants[$];

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 1; mem_rdata = 0;

    //  ir ia       dr dw da       dd            rdy rd            mreq mwe maddr    mwdata        iack dack if_rdata      d_rdata       sf sm
    add(1, 32'h100, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0,        1, 0); // 0
    add(1, 32'h100, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0);
    add(1, 32'h100, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h100, 32'h0,        1, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    add(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    add(1, 32'h104, 1, 1, 32'h200, 32'h12345678, 1, 32'h0,        0, 0, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        1, 1); // 4
    add(1, 32'h104, 1, 1, 32'h200, 32'h12345678, 1, 32'h0,        1, 1, 32'h200, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        1, 1);
    add(1, 32'h104, 1, 1, 32'h200, 32'h12345678, 1, 32'h0,        0, 0, 32'h200, 32'h12345678, 0, 1, 32'hDEADBEEF, 32'h0,        1, 0);
    add(1, 32'h104, 0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h200, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        1, 0);
    add(1, 32'h104, 0, 0, 32'h0,   32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h104, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        1, 0); // 8
    add(1, 32'h104, 0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h104, 32'h12345678, 1, 0, 32'hCAFEF00D, 32'h0,        0, 0);
    add(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h104, 32'h12345678, 0, 0, 32'hCAFEF00D, 32'h0,        0, 0);
    add(0, 32'h0,   1, 0, 32'h300, 32'h0,        0, 32'h0,        0, 0, 32'h104, 32'h12345678, 0, 0, 32'hCAFEF00D, 32'h0,        0, 1);
    for (int k = 0; k < 4; k++)
      add(0, 32'h0, 1, 0, 32'h300, 32'h0,        0, 32'h0,        1, 0, 32'h300, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0,        0, 1);
    add(0, 32'h0,   1, 0, 32'h300, 32'h0,        1, 32'h0BADF00D, 1, 0, 32'h300, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0,        0, 1); // 16
    add(0, 32'h0,   1, 0, 32'h300, 32'h0,        1, 32'h0,        0, 0, 32'h300, 32'h0,        0, 1, 32'hCAFEF00D, 32'h0BADF00D, 0, 0);
    add(0, 32'h0,   1, 1, 32'h400, 32'h55AA55AA, 1, 32'h99999999, 0, 0, 32'h300, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0BADF00D, 0, 1);
    add(0, 32'h0,   1, 1, 32'h400, 32'h55AA55AA, 1, 32'h99999999, 1, 1, 32'h400, 32'h55AA55AA, 0, 0, 32'hCAFEF00D, 32'h0BADF00D, 0, 1);
    add(0, 32'h0,   1, 1, 32'h400, 32'h55AA55AA, 1, 32'h0,        0, 0, 32'h400, 32'h55AA55AA, 0, 1, 32'hCAFEF00D, 32'h0BADF00D, 0, 0); // 20
    add(1, 32'h108, 0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h400, 32'h55AA55AA, 0, 0, 32'hCAFEF00D, 32'h0BADF00D, 1, 0);
    add(1, 32'h108, 0, 0, 32'h0,   32'h0,        1, 32'h22222222, 1, 0, 32'h108, 32'h55AA55AA, 0, 0, 32'hCAFEF00D, 32'h0BADF00D, 1, 0);
    add(1, 32'h108, 0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h108, 32'h55AA55AA, 1, 0, 32'h22222222, 32'h0BADF00D, 0, 0);
    add(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 0, 32'h108, 32'h55AA55AA, 0, 0, 32'h22222222, 32'h0BADF00D, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    check("reset_state", outs(), 134'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req;     d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr;   d_wdata = vecs[i].d_wdata;
      mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
      #2;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      tick();
    end

    // Reset while granted to fetch with memory stalled.
    if_req = 1; if_addr = 32'h500; mem_ready = 0; mem_rdata = 32'h0;
    tick();
    check("gnt_i_before_reset", {133'h0, mem_req}, 134'h1);
    #1 reset = 1'b1;
    #1;
    check("reset_in_gnt", {mem_req, if_ack, if_rdata, mem_addr}, 134'h0);
    tick();
    check("no_ack_in_reset", {mem_req, if_ack}, 134'h0);
    reset = 1'b0; mem_ready = 1; mem_rdata = 32'h77777777;
    tick();
    check("rearb_gnt", {mem_req, mem_we, mem_addr}, {100'h0, 1'b1, 1'b0, 32'h500});
    tick();
    check("rearb_ack", {if_ack, d_ack, if_rdata}, {100'h0, 1'b1, 1'b0, 32'h77777777});
    if_req = 0;
    tick();

    // Reset during the ack cycle.
    if_req = 1; if_addr = 32'h600;
    tick();
    tick();
    check("done_ack_before_reset", {133'h0, if_ack}, 134'h1);
    #1 reset = 1'b1;
    #1;
    check("reset_in_done", {mem_req, if_ack, d_ack}, 134'h0);
    tick();
    reset = 1'b0; if_req = 0;
    tick();

    // Both requesters held continuously; last_grant starts at FETCH after reset.
    if_req = 1; if_addr = 32'h700; d_req = 1; d_we = 0; d_addr = 32'h800; mem_ready = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if_ack || d_ack) grants.push_back(d_ack);
    end
    if_req = 0; d_req = 0;
    check("contention_ack_count", 134'(grants.size()), 134'd4);
    for (int k = 0; k < grants.size(); k++) begin
      logic e;
      e = RR ? ((k % 2) == 0) : 1'b1;
      check($sformatf("contention_grant%0d", k), {133'h0, grants[k]}, {133'h0, e});
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters:
  AW  32  address width
  DW  32  data width
REQ-002 The block SHALL have these ports:
  clk        in   1   clock; all state changes on rising edge
  reset      in   1   asynchronous, active-high reset
  if_req     in   1   fetch-stage read request; held until if_ack
  if_addr    in   AW  fetch address
  if_rdata   out  DW  fetch read data; valid while if_ack=1
  if_ack     out  1   fetch completion pulse, 1 cycle
  d_req      in   1   memory-stage request; held until d_ack
  d_we       in   1   1=store, 0=load
  d_addr     in   AW  data address
  d_wdata    in   DW  store data
  d_rdata    out  DW  load data; valid while d_ack=1
  d_ack      out  1   data completion pulse, 1 cycle
  mem_req    out  1   single shared memory port request
  mem_we     out  1   memory write enable
  mem_addr   out  AW  memory address
  mem_wdata  out  DW  memory write data
  mem_rdata  in   DW  memory read data; valid with mem_ready
  mem_ready  in   1   memory completes the current access this cycle
  stall_f    out  1   if_req & ~if_ack; to hazard unit
  stall_m    out  1   d_req & ~d_ack; to hazard unit
REQ-003 Clock SHALL be the single clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, GNT_D, GNT_I, DONE.
REQ-005 IDLE: if no request, stay. Both requests: pick per REQ-012. One request: grant it. Latch addr, we and wdata of the winner; enter GNT_D or GNT_I.
REQ-006 GNT_x: mem_req=1, driven from latched registers only. mem_we = latched d_we in GNT_D; mem_we = 0 in GNT_I. Stay while mem_ready=0.
REQ-007 GNT_x with mem_ready=1: capture mem_rdata into the winner's rdata register (loads and fetches only; stores leave d_rdata unchanged). Enter DONE.
REQ-008 DONE: the winner's ack=1 for exactly this cycle. All requests are ignored in DONE. Return to IDLE.
REQ-009 Zero-wait memory latency SHALL be: request seen in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 2, IDLE at cycle 3.
REQ-010 if_ack and d_ack SHALL never be 1 together. mem_req SHALL be 0 in IDLE and DONE.
REQ-011 stall_f and stall_m SHALL be combinational. A request arriving while the other is being served SHALL stall until its own ack.
REQ-012 Arbitration SHALL follow REQ-016/017. last_grant is a 1-bit register, updated on entry to GNT_x.

Reset
REQ-013 Reset SHALL drive: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ack=0, d_ack=0; if_rdata=0, d_rdata=0; last_grant=FETCH.
REQ-014 Reset asserted during GNT_x SHALL drop mem_req immediately, with no ack issued. After release, a still-held request SHALL be re-arbitrated from IDLE.
REQ-015 Reset asserted during DONE SHALL suppress the ack at once.

Configuration
REQ-016 With ARB_ROUND_ROBIN_EN undefined: fixed priority, data over fetch.
REQ-017 With ARB_ROUND_ROBIN_EN defined: when both requests are pending, grant the one not equal to last_grant. A single request is always granted.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the FSM state encoding (2-bit) and the grant constants GRANT_FETCH=0, GRANT_DATA=1.
REQ-019 Sub-module arb_pick SHALL hold the winner selection (inputs if_req, d_req, last_grant; output grant). It is the only place ARB_ROUND_ROBIN_EN is tested.

Verification
REQ-020 Fetch only, if_addr=0x100, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_req at cycle 1; if_ack=1 with if_rdata=0xDEADBEEF at cycle 2; stall_f=1 cycles 0-1.
REQ-021 d_req(store 0x200, 0x12345678) and if_req in the same cycle, fixed priority -> GNT_D first with mem_we=1; d_ack; DONE; then GNT_I; if_ack 3 cycles after d_ack.
REQ-022 ARB_ROUND_ROBIN_EN, both requests held continuously for 12 cycles -> grants alternate D,I,D,I; neither requester waits for more than one other access.
REQ-023 Load 0x300 with mem_ready low for 4 cycles -> mem_req and mem_addr stable for 5 cycles; d_ack 1 cycle after mem_ready; stall_m high throughout.
REQ-024 Reset asserted in GNT_I with mem_ready=0 -> mem_req=0 in the same cycle, no if_ack. After release with if_req held -> fresh access served normally.
REQ-025 Store followed by a fetch -> d_rdata keeps its prior load value; if_ack and d_ack never overlap.
